// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   hzd_state_t : controller FSM state encoding
//   regbits_t   : register-select type (REGBITS_W wide)
package pipeline_hazard_ctrl_pkg;

   localparam int REGBITS_W = 5;

   typedef logic [REGBITS_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } hzd_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the datapath and the stall/flush controller.
//   master : datapath side, drives hit/hazard status, receives enables/flushes/counters
//   slave  : controller side
// Signals:
//   ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_branch, ex_memread,
//   ex_wsel, id_rs, id_rt, id_uses_rt           status from the pipeline
//   stage_wen, stage_flush, pc_wen, imemREN       per-cycle pipeline control
//   halted, stall_cnt, flush_cnt                  registered status
interface pipeline_hazard_ctrl_if
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int NSTAGES = 5,
   parameter int RSEL_W  = REGBITS_W,
   parameter int COUNT_W = 32
);
   logic               ihit;
   logic               dhit;
   logic               mem_dREN;
   logic               mem_dWEN;
   logic               mem_halt;
   logic               ex_branch;
   logic               ex_memread;
   logic [RSEL_W-1:0]  ex_wsel;
   logic [RSEL_W-1:0]  id_rs;
   logic [RSEL_W-1:0]  id_rt;
   logic               id_uses_rt;

   logic [NSTAGES-2:0] stage_wen;
   logic [NSTAGES-2:0] stage_flush;
   logic               pc_wen;
   logic               imemREN;
   logic               halted;
   logic [COUNT_W-1:0] stall_cnt;
   logic [COUNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_branch, ex_memread,
             ex_wsel, id_rs, id_rt, id_uses_rt,
      input  stage_wen, stage_flush, pc_wen, imemREN, halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_branch, ex_memread,
             ex_wsel, id_rs, id_rt, id_uses_rt,
      output stage_wen, stage_flush, pc_wen, imemREN, halted, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, never wraps.
//   CLK   : clock
//   nRST  : async active-low reset, clears count
//   inc   : count enable
//   count : current value
module sat_counter #(
   parameter int COUNT_W = 32
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/halt controller for an NSTAGES-deep pipeline.
// Turns ihit/dhit, the MEM-stage data request, EX branch resolution and the
// ID/EX load-use hazard into per-register write-enables/flushes, PC
// write-enable and the instruction read request. Latches HALT and keeps
// saturating stall/flush counters.
//   CLK  : clock, rising edge
//   nRST : async active-low reset
//   bus  : hazard-control bus (slave side)
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal operation
// DWAIT  | data access outstanding in MEM, pipeline frozen
// HALTED | HALT retired from MEM; everything off until reset
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int NSTAGES   = 5,
   parameter int MEM_STAGE = 3,
   parameter int RSEL_W    = REGBITS_W,
   parameter int COUNT_W   = 32
) (
   input logic                   CLK,
   input logic                   nRST,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam int NREG = NSTAGES - 1;

   if ((NSTAGES < 5) || (NSTAGES > 8)) begin : g_bad_nstages
      $error("pipeline_hazard_ctrl: NSTAGES must be 5..8");
   end
   if ((MEM_STAGE < 3) || (MEM_STAGE > NSTAGES - 2)) begin : g_bad_mem_stage
      $error("pipeline_hazard_ctrl: MEM_STAGE must be 3..NSTAGES-2");
   end
   if (RSEL_W < 1) begin : g_bad_rsel
      $error("pipeline_hazard_ctrl: RSEL_W must be positive");
   end

   hzd_state_t      state_q;
   logic            halted_q;

   logic            dreq;
   logic            dmiss;
   logic            load_use;
   logic [NREG-1:0] wen;
   logic [NREG-1:0] flush;
   logic            pc_wen;
   logic            imem_ren;
   logic            inc_stall;
   logic            inc_flush;

   always_comb begin
      dreq  = bus.mem_dREN | bus.mem_dWEN;
      dmiss = dreq & ~bus.dhit;
   end

   // r0 never creates a dependency, so ex_wsel==0 is excluded.
   always_comb begin
      load_use = bus.ex_memread && (bus.ex_wsel != '0) &&
                 ((bus.ex_wsel == bus.id_rs) ||
                  (bus.id_uses_rt && (bus.ex_wsel == bus.id_rt)));
   end

   // Only the IF/ID and ID/EX registers are ever flushed; later registers
   // either freeze on a data miss or advance.
   always_comb begin
      wen      = '0;
      flush    = '0;
      pc_wen   = 1'b0;
      imem_ren = 1'b0;
      if (state_q == HALTED) begin
         wen = '0;
      end else if (dmiss) begin
         wen = '0;
      end else if (dreq) begin
         wen      = '1;
         flush[0] = 1'b1;
      end else if (bus.ex_branch) begin
         wen      = '1;
         flush[0] = 1'b1;
         flush[1] = 1'b1;
         pc_wen   = 1'b1;
         imem_ren = 1'b1;
      end else if (load_use) begin
         wen      = '1;
         wen[0]   = 1'b0;
         flush[1] = 1'b1;
         imem_ren = 1'b1;
      end else if (!bus.ihit) begin
         wen      = '1;
         flush[0] = 1'b1;
         imem_ren = 1'b1;
      end else begin
         wen      = '1;
         pc_wen   = 1'b1;
         imem_ren = 1'b1;
      end
   end

   // HALT is only taken once the MEM-stage access is no longer stalling,
   // so a halt behind a pending load/store waits for its dhit.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= RUN;
         halted_q <= 1'b0;
      end else if (bus.mem_halt && !dmiss) begin
         state_q  <= HALTED;
         halted_q <= 1'b1;
      end else begin
         case (state_q)
            HALTED:  state_q <= HALTED;
            default: state_q <= dmiss ? DWAIT : RUN;
         endcase
      end
   end

   always_comb begin
      inc_stall = (state_q != HALTED) & ~pc_wen;
      inc_flush = (state_q != HALTED) & flush[1];
   end

   sat_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (inc_stall),
      .count (bus.stall_cnt)
   );

   sat_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .inc   (inc_flush),
      .count (bus.flush_cnt)
   );

   assign bus.stage_wen   = wen;
   assign bus.stage_flush = flush;
   assign bus.pc_wen      = pc_wen;
   assign bus.imemREN     = imem_ren;
   assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   logic CLK;
   logic nRST;
   logic rst4_n;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl_if #(.NSTAGES(5), .RSEL_W(5), .COUNT_W(32)) bus ();
   pipeline_hazard_ctrl_if #(.NSTAGES(5), .RSEL_W(5), .COUNT_W(4))  b4 ();

   pipeline_hazard_ctrl #(.NSTAGES(5), .MEM_STAGE(3), .RSEL_W(5), .COUNT_W(32)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   pipeline_hazard_ctrl #(.NSTAGES(5), .MEM_STAGE(3), .RSEL_W(5), .COUNT_W(4)) dut4 (
      .CLK  (CLK),
      .nRST (rst4_n),
      .bus  (b4.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int          id;
      logic [3:0]  wen;
      logic [3:0]  fl;
      logic        pc;
      logic        im;
      logic        hl;
      logic [31:0] sc;
      logic [31:0] fc;
      logic        cs;
      hzd_state_t  st;
   } exp_t;

   exp_t exp_q[$];
   int   cyc_id = 0;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, id, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drv(input logic ih, input logic dr, input logic dw, input logic dh,
                      input logic hlt, input logic br, input logic mr,
                      input logic [4:0] ws, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt);
      bus.ihit       = ih;
      bus.mem_dREN   = dr;
      bus.mem_dWEN   = dw;
      bus.dhit       = dh;
      bus.mem_halt   = hlt;
      bus.ex_branch  = br;
      bus.ex_memread = mr;
      bus.ex_wsel    = ws;
      bus.id_rs      = rs;
      bus.id_rt      = rt;
      bus.id_uses_rt = urt;
   endtask

   task automatic ex(input logic [3:0] wen, input logic [3:0] fl, input logic pc, input logic im,
                     input logic hl, input int sc, input int fc, input logic cs, input hzd_state_t st);
      exp_t e;
      cyc_id++;
      e.id = cyc_id; e.wen = wen; e.fl = fl; e.pc = pc; e.im = im; e.hl = hl;
      e.sc = sc; e.fc = fc; e.cs = cs; e.st = st;
      exp_q.push_back(e);
   endtask

   // Monitor: combinational outputs are valid mid-cycle; compare on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stage_wen",   e.id, {28'd0, bus.stage_wen},   {28'd0, e.wen});
            chk("stage_flush", e.id, {28'd0, bus.stage_flush}, {28'd0, e.fl});
            chk("pc_wen",      e.id, {31'd0, bus.pc_wen},      {31'd0, e.pc});
            chk("imemREN",     e.id, {31'd0, bus.imemREN},     {31'd0, e.im});
            chk("halted",      e.id, {31'd0, bus.halted},      {31'd0, e.hl});
            chk("stall_cnt",   e.id, bus.stall_cnt,            e.sc);
            chk("flush_cnt",   e.id, bus.flush_cnt,            e.fc);
            if (e.cs) chk("state", e.id, {30'd0, dut.state_q}, {30'd0, e.st});
         end
      end
   end

   initial begin
      nRST   = 1'b0;
      rst4_n = 1'b0;
      drv(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      b4.ihit = 1'b0; b4.dhit = 1'b0; b4.mem_dREN = 1'b0; b4.mem_dWEN = 1'b0;
      b4.mem_halt = 1'b0; b4.ex_branch = 1'b0; b4.ex_memread = 1'b0;
      b4.ex_wsel = 5'd0; b4.id_rs = 5'd0; b4.id_rt = 5'd0; b4.id_uses_rt = 1'b0;
      tick(); tick();
      chk("rst_halted",    0, {31'd0, bus.halted}, 32'd0);
      chk("rst_stall_cnt", 0, bus.stall_cnt, 32'd0);
      chk("rst_flush_cnt", 0, bus.flush_cnt, 32'd0);
      chk("rst_state",     0, {30'd0, dut.state_q}, {30'd0, RUN});
      nRST = 1'b1;

      //  ih dr dw dh hl br mr ws rs rt urt        wen    fl     pc im hl sc  fc cs st
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h0, 1, 1, 0, 0,  0, 1, RUN);    tick(); // 1 idle
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h1, 0, 1, 0, 0,  0, 0, RUN);    tick(); // 2 !ihit
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h1, 0, 1, 0, 1,  0, 0, RUN);    tick(); // 3
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h1, 0, 1, 0, 2,  0, 0, RUN);    tick(); // 4
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h0, 1, 1, 0, 3,  0, 0, RUN);    tick(); // 5
      drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'h0, 4'h0, 0, 0, 0, 3,  0, 1, RUN);    tick(); // 6 load miss
      drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'h0, 4'h0, 0, 0, 0, 4,  0, 1, DWAIT);  tick(); // 7 miss
      drv(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h1, 0, 0, 0, 5,  0, 1, DWAIT);  tick(); // 8 hit
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h0, 1, 1, 0, 6,  0, 1, RUN);    tick(); // 9
      drv(1, 0, 0, 0, 0, 0, 1, 5, 5, 0, 0); ex(4'hE, 4'h2, 0, 1, 0, 6,  0, 0, RUN);    tick(); // 10 load-use rs
      drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); ex(4'hF, 4'h0, 1, 1, 0, 7,  1, 0, RUN);    tick(); // 11 wsel=0
      drv(1, 0, 0, 0, 0, 0, 1, 7, 3, 7, 1); ex(4'hE, 4'h2, 0, 1, 0, 7,  1, 0, RUN);    tick(); // 12 load-use rt
      drv(1, 0, 0, 0, 0, 0, 1, 7, 3, 7, 0); ex(4'hF, 4'h0, 1, 1, 0, 8,  2, 0, RUN);    tick(); // 13 rt unused
      drv(1, 0, 0, 0, 0, 1, 1, 5, 5, 0, 0); ex(4'hF, 4'h3, 1, 1, 0, 8,  2, 0, RUN);    tick(); // 14 branch wins
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h0, 1, 1, 0, 8,  3, 0, RUN);    tick(); // 15
      drv(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0); ex(4'h0, 4'h0, 0, 0, 0, 8,  3, 0, RUN);    tick(); // 16 store miss+br
      drv(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0); ex(4'hF, 4'h1, 0, 0, 0, 9,  3, 1, DWAIT);  tick(); // 17 hit+br
      drv(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0); ex(4'h0, 4'h0, 0, 0, 0, 10, 3, 1, RUN);    tick(); // 18 halt blocked
      drv(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h0, 1, 1, 0, 11, 3, 1, DWAIT);  tick(); // 19 halt taken
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'h0, 4'h0, 0, 0, 1, 11, 3, 1, HALTED); tick(); // 20
      drv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); ex(4'h0, 4'h0, 0, 0, 1, 11, 3, 1, HALTED); tick(); // 21
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'h0, 4'h0, 0, 0, 1, 11, 3, 1, HALTED); tick(); // 22
      nRST = 1'b0;
      tick(); tick();
      nRST = 1'b1;
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h0, 1, 1, 0, 0,  0, 1, RUN);    tick(); // 23 after reset
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h1, 0, 1, 0, 0,  0, 1, RUN);    tick(); // 24
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex(4'hF, 4'h0, 1, 1, 0, 1,  0, 1, RUN);    tick(); // 25

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      // 4-bit counter instance: constant !ihit stalls every cycle.
      rst4_n = 1'b1;
      repeat (14) @(posedge CLK);
      #1;
      chk("sat4_stall_14", 0, {28'd0, b4.stall_cnt}, 32'd14);
      repeat (6) @(posedge CLK);
      #1;
      chk("sat4_stall_20", 0, {28'd0, b4.stall_cnt}, 32'd15);
      chk("sat4_flush",    0, {28'd0, b4.flush_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

endmodule
